// File: rtl/apb_poll_master.sv
// APB3 requester for the tune-detector peripheral bus.
// Runs single read/write commands taken over a valid/ready port. It can also poll one register
// periodically and cache the last good read for the datapath. Wait states are handled through
// PREADY and PSLVERR is captured. A transfer that never completes is aborted after TIMEOUT
// ACCESS cycles.
//
// Ports:
//   PCLK, PRESETn              clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_*     command request (write flag, word address, write data)
//   rsp_valid, rsp_*           one-cycle command response (read data, error, timeout flag)
//   poll_en, poll_addr         periodic poll enable and address (sampled at launch)
//   poll_data, poll_update     last successful poll read and its update pulse
//   poll_err                   sticky poll error/timeout flag, cleared by poll_en = 0
//   PSEL .. PSLVERR            APB3 requester signals
module apb_poll_master #(
  parameter int unsigned POLL_DIV = 1024,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [11:2]  cmd_addr,
  input  logic [31:0]  cmd_wdata,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output logic         rsp_timeout,
  input  logic         poll_en,
  input  logic [11:2]  poll_addr,
  output logic [31:0]  poll_data,
  output logic         poll_update,
  output logic         poll_err,
  output logic         PSEL,
  output logic         PENABLE,
  output logic         PWRITE,
  output logic [11:2]  PADDR,
  output logic [31:0]  PWDATA,
  input  logic [31:0]  PRDATA,
  input  logic         PREADY,
  input  logic         PSLVERR
);

  localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PollMax    = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e        state_q, state_d;
  logic [11:2]   paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          is_poll_q, is_poll_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_pend_q, poll_pend_d;
  logic [TW-1:0] tout_cnt_q, tout_cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [31:0]   poll_data_q, poll_data_d;
  logic          poll_update_q, poll_update_d;
  logic          poll_err_q, poll_err_d;

  logic done, abort, xfer_err, launch_poll, poll_busy;

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    is_poll_d     = is_poll_q;
    tout_cnt_d    = tout_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    poll_data_d   = poll_data_q;
    poll_update_d = 1'b0;
    poll_err_d    = poll_err_q;
    poll_cnt_d    = poll_cnt_q;
    poll_pend_d   = poll_pend_q;
    cmd_ready     = 1'b0;
    PSEL          = 1'b0;
    PENABLE       = 1'b0;
    done          = 1'b0;
    abort         = 1'b0;
    launch_poll   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d   = StSetup;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          is_poll_d = 1'b0;
        end else if (poll_pend_q) begin
          state_d     = StSetup;
          paddr_d     = poll_addr;
          pwrite_d    = 1'b0;
          pwdata_d    = '0;
          is_poll_d   = 1'b1;
          launch_poll = 1'b1;
        end
      end
      StSetup: begin
        PSEL       = 1'b1;
        tout_cnt_d = '0;
        state_d    = StAccess;
      end
      StAccess: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          state_d = StIdle;
          done    = 1'b1;
        end else if (tout_cnt_q == TimeoutMax) begin
          state_d = StIdle;
          abort   = 1'b1;
        end else begin
          tout_cnt_d = tout_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // PSLVERR only means something when PREADY completed the transfer.
    xfer_err = abort | (done & PSLVERR);
    if (done || abort) begin
      if (is_poll_q) begin
        if (!xfer_err) begin
          poll_data_d   = PRDATA;
          poll_update_d = 1'b1;
        end else begin
          poll_err_d = 1'b1;
        end
      end else begin
        rsp_valid_d   = 1'b1;
        rsp_err_d     = xfer_err;
        rsp_timeout_d = abort;
        rsp_rdata_d   = (!pwrite_q && !xfer_err) ? PRDATA : '0;
      end
    end

    // The poll counter holds while a poll is pending or on the bus, so the period runs from the
    // previous completion and expiries can never stack up behind a pending poll.
    poll_busy = is_poll_q && (state_q != StIdle);
    if (!poll_en) begin
      poll_cnt_d  = '0;
      poll_pend_d = 1'b0;
      poll_err_d  = 1'b0;
    end else begin
      if (launch_poll) poll_pend_d = 1'b0;
      if (!poll_pend_q && !poll_busy) begin
        if (poll_cnt_q == PollMax) begin
          poll_cnt_d  = '0;
          poll_pend_d = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= StIdle;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      is_poll_q     <= 1'b0;
      poll_cnt_q    <= '0;
      poll_pend_q   <= 1'b0;
      tout_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      poll_data_q   <= '0;
      poll_update_q <= 1'b0;
      poll_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      is_poll_q     <= is_poll_d;
      poll_cnt_q    <= poll_cnt_d;
      poll_pend_q   <= poll_pend_d;
      tout_cnt_q    <= tout_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      poll_data_q   <= poll_data_d;
      poll_update_q <= poll_update_d;
      poll_err_q    <= poll_err_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign poll_data   = poll_data_q;
  assign poll_update = poll_update_q;
  assign poll_err    = poll_err_q;

endmodule

// File: doc/apb_poll_master.md
# apb_poll_master

APB3 requester (bus master) that drives the tune-detector peripheral bus from the processing side of the SDR SoC. It accepts single read/write commands over a valid/ready port and can also poll one register address periodically, such as the 27-bit RSSI accumulator register, caching the latest value for the datapath. It sits between internal control logic and APB completers. It handles wait states through PREADY, captures PSLVERR, and aborts hung transfers with a timeout.

## Interface
- POLL_DIV, 1024: poll period in PCLK cycles (≥4).
- TIMEOUT, 255: maximum ACCESS cycles before abort (≥1).

- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  [11:2]  word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse for a command (no backpressure).
- rsp_rdata  out  32  read data; 0 for writes, errors and timeouts.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- rsp_timeout  out  1  timeout abort; valid with rsp_valid.
- poll_en  in  1  enables periodic polling.
- poll_addr  in  [11:2]  address to poll (sampled at poll launch).
- poll_data  out  32  last successful poll read.
- poll_update  out  1  one-cycle pulse when poll_data is updated.
- poll_err  out  1  sticky; set on a poll error or timeout; cleared when poll_en goes low.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  [11:2]  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready = 1. If cmd_valid is high, go to SETUP(cmd). Otherwise, if poll pending, go to SETUP(poll).
  - SETUP: PSEL = 1, PENABLE = 0. Go to ACCESS unconditionally.
  - ACCESS: PSEL = 1, PENABLE = 1. On PREADY, go to IDLE. If the timeout count reaches TIMEOUT, go to IDLE with an abort.
- Arbitration: a command beats a pending poll in the same IDLE cycle. The poll stays pending.
- Polls are always reads.
- PADDR, PWRITE and PWDATA are loaded on the IDLE→SETUP transition and held stable through the end of ACCESS. They keep their last value while idle.
- Read transfers drive PWDATA = 0.
- Poll counter:
  - Counts 0..POLL_DIV-1 while poll_en = 1. Reaching POLL_DIV-1 sets poll pending and wraps to 0.
  - An expiry while a poll is already pending is dropped, so requests do not accumulate.
  - poll_en = 0 clears the counter, the pending flag and poll_err. A poll already on the bus still completes.
- Completion:
  - On PREADY in ACCESS, PRDATA and PSLVERR are sampled.
  - Command: rsp_valid = 1 next cycle. rsp_rdata = PRDATA for a read with no error, else 0.
  - Poll: if no error, poll_data = PRDATA and poll_update = 1. If error, poll_data is unchanged and poll_err = 1.
- Timeout:
  - An ACCESS-cycle counter is cleared in SETUP.
  - When TIMEOUT cycles elapse without PREADY, PSEL and PENABLE drop and the transfer is reported as an error with rsp_timeout = 1 (command) or poll_err = 1 (poll).

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - All outputs 0, except cmd_ready = 1 from IDLE.
  - poll_data = 0; both counters = 0.
- Reset mid-transfer: PSEL and PENABLE drop immediately. No response is issued.
- Zero-wait command sequence:
  - T0: accept.
  - T1: SETUP.
  - T2: ACCESS with PREADY = 1.
  - T3: rsp_valid = 1, IDLE, cmd_ready = 1.
  - Back-to-back commands therefore run one every 3 cycles.
- N wait states add N cycles.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, and rsp_valid follows on the next cycle.
- cmd_ready is 0 from SETUP until return to IDLE.
- A command offered during a poll transfer waits; it is accepted in the first IDLE cycle.
- rsp_valid and poll_update are single-cycle pulses, registered, and never asserted in the same cycle.

## Test plan
- Command write addr 0x004, data 0xDEADBEEF, completer PREADY = 1 → PSEL rises at T1, PENABLE at T2; rsp_valid at T3 with rsp_err = 0 and rsp_rdata = 0.
- Command read addr 0x001, completer 2 wait states returning 0x05ABCDEF → ACCESS lasts 3 cycles; rsp_rdata = 0x05ABCDEF, rsp_valid at T5.
- Read with PSLVERR = 1 and PRDATA = 0x1234 → rsp_err = 1, rsp_rdata = 0, rsp_timeout = 0.
- PREADY held 0 with TIMEOUT = 255 → ACCESS for 255 cycles, then PSEL = 0; rsp_valid with rsp_err = 1 and rsp_timeout = 1.
- poll_en = 1, POLL_DIV = 16, completer returns an incrementing count → poll_update pulses every 19 cycles (16-cycle period plus 3-cycle transfer) and poll_data tracks the count.
- cmd_valid asserted in the same cycle a poll becomes pending → the command goes first; the poll launches in the IDLE cycle after rsp_valid.
- PRESETn pulsed low during ACCESS → PSEL and PENABLE drop asynchronously, no rsp_valid; after release, cmd_ready = 1 and poll_data = 0.
